hamming_secded_codec: RTL

Parametrised Hamming SECDED (single-error-correct, double-error-detect) codec. It generalises the fixed 26→32-bit Hamming encoder to any data width and adds a decode path: syndrome computation, single-bit correction, double-error flagging and saturating error counters. It sits between a data producer and a storage or link stage. Encode and decode are independent valid/ready streams, each with one registered output stage.

---
 rtl/hamming_pkg.sv | 42 ++++
 rtl/hamming_syndrome.sv | 22 ++
 rtl/hamming_secded_codec.sv | 130 +++++++++++++
 3 files changed

// File: rtl/hamming_pkg.sv
// Shared helpers for the parametrised Hamming SECDED codec.
// Codeword layout: bit 0 = overall parity, power-of-two positions = Hamming
// parity, all other positions hold data bits in ascending order (data[0] at 3).
package hamming_pkg;

  // Smallest P with 2^P >= dw + P + 1.
  function automatic int calc_p(input int dw);
    int p;
    for (p = 1; (1 << p) < dw + p + 1; p++) begin
    end
    return p;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Code position -> data index (only meaningful for non-power-of-two pos >= 3).
  function automatic int pos2idx(input int pos);
    int n;
    n = 0;
    for (int b = 0; b < 31; b++)
      if ((1 << b) <= pos) n++;
    return pos - n - 1;
  endfunction

  // Data index -> code position.
  function automatic int idx2pos(input int idx);
    int k;
    int res;
    k   = 0;
    res = 0;
    for (int q = 3; q < 4096; q++) begin
      if (!is_pow2(q)) begin
        if (k == idx) res = q;
        k++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome / overall-parity generator.
//   code : codeword (bit 0 = overall parity position)
//   syn  : XOR of positions 1..CODE_W-1 selected per syndrome bit
//   ovr  : XOR of all CODE_W bits
module hamming_syndrome #(
  parameter int CODE_W = 32,
  parameter int P      = 5
) (
  input  logic [CODE_W-1:0] code,
  output logic [P-1:0]      syn,
  output logic              ovr
);

  always_comb begin
    syn = '0;
    for (int q = 1; q < CODE_W; q++)
      for (int i = 0; i < P; i++)
        if (((q >> i) & 1) != 0) syn[i] = syn[i] ^ code[q];
    ovr = ^code;
  end

endmodule

// File: rtl/hamming_secded_codec.sv
// Hamming SECDED codec: independent encode and decode valid/ready streams,
// each with one registered output stage, plus saturating SEC/DED counters.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   enc_* / encq_*        : encode input / registered codeword output
//   dec_* / decq_*        : decode input / registered corrected-data output
//   sec_count, ded_count  : saturating event counters, cleared by cnt_clear
module hamming_secded_codec
  import hamming_pkg::*;
#(
  parameter int DATA_W = 26,
  parameter int CNT_W  = 16,
  localparam int P      = calc_p(DATA_W),
  localparam int CODE_W = DATA_W + P + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enc_valid,
  output logic              enc_ready,
  input  logic [DATA_W-1:0] enc_data,
  output logic              encq_valid,
  input  logic              encq_ready,
  output logic [CODE_W-1:0] encq_code,
  input  logic              dec_valid,
  output logic              dec_ready,
  input  logic [CODE_W-1:0] dec_code,
  output logic              decq_valid,
  input  logic              decq_ready,
  output logic [DATA_W-1:0] decq_data,
  output logic              decq_sec,
  output logic              decq_ded,
  output logic [P-1:0]      decq_pos,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count,
  input  logic              cnt_clear
);

  // ---------------- encode datapath ----------------
  logic [CODE_W-1:0] placed, enc_code;
  logic [P-1:0]      enc_syn;
  logic              enc_ovr;

  always_comb begin
    placed = '0;
    for (int q = 1; q < CODE_W; q++)
      if (!is_pow2(q)) placed[q] = enc_data[pos2idx(q)];
  end

  hamming_syndrome #(.CODE_W(CODE_W), .P(P)) u_enc_syn (
    .code(placed), .syn(enc_syn), .ovr(enc_ovr)
  );

  // With parity slots zero, the syndrome is exactly the parity bit values.
  // Overall parity then covers data (enc_ovr) plus the inserted parity bits.
  always_comb begin
    enc_code = placed;
    for (int i = 0; i < P; i++) enc_code[1 << i] = enc_syn[i];
    enc_code[0] = enc_ovr ^ (^enc_syn);
  end

  // ---------------- decode datapath ----------------
  logic [P-1:0]      dec_syn, dec_pos;
  logic              dec_ovr, dec_sec, dec_ded;
  logic [CODE_W-1:0] corrected;
  logic [DATA_W-1:0] dec_data;

  hamming_syndrome #(.CODE_W(CODE_W), .P(P)) u_dec_syn (
    .code(dec_code), .syn(dec_syn), .ovr(dec_ovr)
  );

  always_comb begin
    // Odd overall parity with an in-range syndrome is a single error; S=0
    // points at the overall parity bit itself.
    dec_sec   = dec_ovr && (int'(dec_syn) < CODE_W);
    dec_ded   = dec_ovr ? !dec_sec : (dec_syn != '0);
    dec_pos   = dec_sec ? dec_syn : '0;
    corrected = dec_code ^ ({{(CODE_W-1){1'b0}}, dec_sec} << dec_syn);
    dec_data  = '0;
    for (int i = 0; i < DATA_W; i++) dec_data[i] = corrected[idx2pos(i)];
  end

  // ---------------- handshakes ----------------
  logic enc_acc, dec_acc;

  assign enc_ready = reset || !encq_valid || encq_ready;
  assign dec_ready = reset || !decq_valid || decq_ready;
  assign enc_acc   = enc_valid && enc_ready;
  assign dec_acc   = dec_valid && dec_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      encq_valid <= 1'b0;
      encq_code  <= '0;
    end else if (enc_acc) begin
      encq_valid <= 1'b1;
      encq_code  <= enc_code;
    end else if (encq_ready) begin
      encq_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      decq_valid <= 1'b0;
      decq_data  <= '0;
      decq_sec   <= 1'b0;
      decq_ded   <= 1'b0;
      decq_pos   <= '0;
    end else if (dec_acc) begin
      decq_valid <= 1'b1;
      decq_data  <= dec_data;
      decq_sec   <= dec_sec;
      decq_ded   <= dec_ded;
      decq_pos   <= dec_pos;
    end else if (decq_ready) begin
      decq_valid <= 1'b0;
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clock) begin
    if (reset || cnt_clear) begin
      sec_count <= '0;
      ded_count <= '0;
    end else if (dec_acc) begin
      if (dec_sec && (sec_count != '1)) sec_count <= sec_count + 1'b1;
      if (dec_ded && (ded_count != '1)) ded_count <= ded_count + 1'b1;
    end
  end

endmodule
